// File: rtl/tb_mon_pkg.sv
// tb_mon_pkg: shared types for the commit monitor.
// FSM states, fail codes and the fail-code width.
package tb_mon_pkg;

    localparam int FC_W = 3;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } mon_state_e;

    typedef enum logic [FC_W-1:0] {
        FC_NONE     = 3'd0,
        FC_TIMEOUT  = 3'd1,
        FC_STALL    = 3'd2,
        FC_MISMATCH = 3'd3,
        FC_MISALIGN = 3'd4
    } fail_code_e;

endpackage

// File: rtl/tb_commit_monitor_if.sv
// tb_commit_monitor_if: commit stream in, verdict/counters out.
// master drives the commit stream; slave is the monitor.
interface tb_commit_monitor_if
    import tb_mon_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic [PC_W-1:0]  i_pc_debug;
    logic             i_insn_vld;
    logic [31:0]      i_io_ledr;
    logic [31:0]      i_expect_ledr;
    logic             o_done;
    logic             o_pass;
    logic [FC_W-1:0]  o_fail_code;
    logic [CNT_W-1:0] o_cyc_cnt;
    logic [CNT_W-1:0] o_insn_cnt;

    modport master (
        output i_pc_debug, i_insn_vld,
        output i_io_ledr, i_expect_ledr,
        input  o_done, o_pass, o_fail_code,
        input  o_cyc_cnt, o_insn_cnt
    );

    modport slave (
        input  i_pc_debug, i_insn_vld,
        input  i_io_ledr, i_expect_ledr,
        output o_done, o_pass, o_fail_code,
        output o_cyc_cnt, o_insn_cnt
    );
endinterface

// File: rtl/tb_sat_cnt.sv
// tb_sat_cnt: W-bit counter that sticks at all-ones.
// Ports: clk_i, rst_i (sync), clear_i, en_i, cnt_o.
module tb_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/tb_commit_monitor.sv
// tb_commit_monitor: end-of-test verdict from the commit stream.
// Ports: i_clk, i_reset (sync, high), bus (slave): commit stream,
// LEDR check, o_done/o_pass/o_fail_code, cycle/insn counters.
// Macro TB_MON_ALIGN_CHK_EN enables the misaligned-PC fault.
module tb_commit_monitor
    import tb_mon_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 40000,
    parameter int STALL_CYC   = 1024,
    parameter int HALT_REPEAT = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    tb_commit_monitor_if.slave  bus
);
    localparam int REP_W = $clog2(HALT_REPEAT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STL_LAST = CNT_W'(STALL_CYC - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(HALT_REPEAT - 1);

    mon_state_e       state_q, state_d;
    fail_code_e       code_q, code_d, fault;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [PC_W-1:0]  last_pc_q, last_pc_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [CNT_W-1:0] cyc_cnt, insn_cnt, stall_cnt;

    logic vld, active, same_pc, halt;
    logic tmo_hit, stall_hit, misalign;

    assign vld     = bus.i_insn_vld;
    assign active  = (state_q == WAIT) || (state_q == RUN);
    assign same_pc = (bus.i_pc_debug == last_pc_q);
    assign halt    = vld && same_pc && (rep_q == REP_LAST);
    // Faults fire on the edge that makes the counter hit its limit.
    assign tmo_hit   = (cyc_cnt >= TMO_LAST);
    assign stall_hit = !vld && (stall_cnt >= STL_LAST);

`ifdef TB_MON_ALIGN_CHK_EN
    assign misalign = vld && (bus.i_pc_debug[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    tb_sat_cnt #(.W(CNT_W)) u_cyc (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .clear_i (1'b0),
        .en_i    (state_q != DONE),
        .cnt_o   (cyc_cnt)
    );

    tb_sat_cnt #(.W(CNT_W)) u_insn (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .clear_i (1'b0),
        .en_i    (active && vld),
        .cnt_o   (insn_cnt)
    );

    tb_sat_cnt #(.W(CNT_W)) u_stall (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .clear_i (vld),
        .en_i    ((state_q == RUN) && !vld),
        .cnt_o   (stall_cnt)
    );

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        done_d    = done_q;
        pass_d    = pass_q;
        last_pc_d = last_pc_q;
        rep_d     = rep_q;
        fault     = FC_NONE;
        unique case (state_q)
            WAIT: begin
                if (vld) begin
                    last_pc_d = bus.i_pc_debug;
                    rep_d     = REP_W'(1);
                    state_d   = RUN;
                end
                if (misalign)     fault = FC_MISALIGN;
                else if (tmo_hit) fault = FC_TIMEOUT;
            end
            RUN: begin
                if (vld) begin
                    if (same_pc) begin
                        rep_d = rep_q + REP_W'(1);
                    end else begin
                        rep_d     = REP_W'(1);
                        last_pc_d = bus.i_pc_debug;
                    end
                end
                // Halt outranks every fault seen on the same edge.
                if (halt)           state_d = CHECK;
                else if (misalign)  fault = FC_MISALIGN;
                else if (stall_hit) fault = FC_STALL;
                else if (tmo_hit)   fault = FC_TIMEOUT;
            end
            CHECK: begin
                state_d = DONE;
                done_d  = 1'b1;
                if (bus.i_io_ledr == bus.i_expect_ledr)
                    pass_d = 1'b1;
                else
                    code_d = FC_MISMATCH;
            end
            DONE: begin
            end
        endcase
        if (fault != FC_NONE) begin
            state_d = DONE;
            done_d  = 1'b1;
            code_d  = fault;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= WAIT;
            code_q    <= FC_NONE;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            last_pc_q <= '0;
            rep_q     <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            last_pc_q <= last_pc_d;
            rep_q     <= rep_d;
        end
    end

    assign bus.o_done      = done_q;
    assign bus.o_pass      = pass_q;
    assign bus.o_fail_code = code_q;
    assign bus.o_cyc_cnt   = cyc_cnt;
    assign bus.o_insn_cnt  = insn_cnt;
endmodule

// File: tb/tb_tb_commit_monitor.sv
// tb_tb_commit_monitor: directed bench for tb_commit_monitor.
// TIMEOUT_CYC=100, STALL_CYC=16, HALT_REPEAT=4.
module tb_tb_commit_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tb_commit_monitor_if #(.PC_W(32), .CNT_W(32)) bus ();

    tb_commit_monitor #(
        .PC_W        (32),
        .CNT_W       (32),
        .TIMEOUT_CYC (100),
        .STALL_CYC   (16),
        .HALT_REPEAT (4)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic commit(logic [31:0] pc);
        bus.i_pc_debug = pc;
        bus.i_insn_vld = 1'b1;
        step(1);
        bus.i_insn_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_insn_vld = 1'b0;
        step(1);
        rst = 1'b0;
    endtask

    task automatic halt_seq();
        commit(32'h0);
        commit(32'h4);
        commit(32'h8);
        commit(32'hC);
        commit(32'hC);
        commit(32'hC);
        commit(32'hC);
    endtask

    initial begin
        bus.i_pc_debug    = '0;
        bus.i_insn_vld    = 1'b0;
        bus.i_io_ledr     = 32'h2A;
        bus.i_expect_ledr = 32'h2A;
        step(2);

        // reset state
        do_reset();
        chk("rst_done", 32'(bus.o_done), 32'd0);
        chk("rst_pass", 32'(bus.o_pass), 32'd0);
        chk("rst_code", 32'(bus.o_fail_code), 32'd0);
        chk("rst_cyc", bus.o_cyc_cnt, 32'd0);
        chk("rst_insn", bus.o_insn_cnt, 32'd0);

        // halt with matching LEDR
        halt_seq();
        chk("halt_check_done", 32'(bus.o_done), 32'd0);
        step(1);
        chk("halt_done", 32'(bus.o_done), 32'd1);
        chk("halt_pass", 32'(bus.o_pass), 32'd1);
        chk("halt_code", 32'(bus.o_fail_code), 32'd0);
        chk("halt_insn", bus.o_insn_cnt, 32'd7);
        step(3);
        chk("halt_cyc_frozen", bus.o_cyc_cnt, 32'd8);

        // LEDR mismatch
        bus.i_io_ledr = 32'h29;
        do_reset();
        halt_seq();
        step(1);
        chk("mm_done", 32'(bus.o_done), 32'd1);
        chk("mm_pass", 32'(bus.o_pass), 32'd0);
        chk("mm_code", 32'(bus.o_fail_code), 32'd3);
        bus.i_io_ledr = 32'h2A;

        // repeat count restarts on a new PC and survives gaps
        do_reset();
        commit(32'h20);
        commit(32'h20);
        commit(32'h20);
        commit(32'h24);
        commit(32'h24);
        commit(32'h24);
        step(2);
        chk("rep_no_halt", 32'(bus.o_done), 32'd0);
        chk("rep_insn6", bus.o_insn_cnt, 32'd6);
        commit(32'h24);
        step(1);
        chk("rep_pass", 32'(bus.o_pass), 32'd1);
        chk("rep_insn7", bus.o_insn_cnt, 32'd7);

        // stall after one commit
        do_reset();
        commit(32'h10);
        step(15);
        chk("stall_early", 32'(bus.o_done), 32'd0);
        step(1);
        chk("stall_done", 32'(bus.o_done), 32'd1);
        chk("stall_code", 32'(bus.o_fail_code), 32'd2);
        chk("stall_cyc", bus.o_cyc_cnt, 32'd17);
        commit(32'h10);
        step(2);
        chk("stall_cyc_frz", bus.o_cyc_cnt, 32'd17);
        chk("stall_insn_frz", bus.o_insn_cnt, 32'd1);
        chk("stall_code_hold", 32'(bus.o_fail_code), 32'd2);

        // global timeout with no commits
        do_reset();
        step(99);
        chk("tmo_early", 32'(bus.o_done), 32'd0);
        chk("tmo_cyc99", bus.o_cyc_cnt, 32'd99);
        step(1);
        chk("tmo_done", 32'(bus.o_done), 32'd1);
        chk("tmo_code", 32'(bus.o_fail_code), 32'd1);
        chk("tmo_cyc", bus.o_cyc_cnt, 32'd100);
        step(3);
        chk("tmo_cyc_frz", bus.o_cyc_cnt, 32'd100);
        chk("tmo_insn", bus.o_insn_cnt, 32'd0);

        // halt on the timeout edge wins, then reset in DONE
        do_reset();
        step(93);
        halt_seq();
        chk("prio_cyc", bus.o_cyc_cnt, 32'd100);
        chk("prio_no_done", 32'(bus.o_done), 32'd0);
        step(1);
        chk("prio_done", 32'(bus.o_done), 32'd1);
        chk("prio_pass", 32'(bus.o_pass), 32'd1);
        chk("prio_code", 32'(bus.o_fail_code), 32'd0);
        chk("prio_cyc_chk", bus.o_cyc_cnt, 32'd101);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("prst_done", 32'(bus.o_done), 32'd0);
        chk("prst_pass", 32'(bus.o_pass), 32'd0);
        chk("prst_code", 32'(bus.o_fail_code), 32'd0);
        chk("prst_cyc", bus.o_cyc_cnt, 32'd0);
        chk("prst_insn", bus.o_insn_cnt, 32'd0);

        // misaligned PC
        do_reset();
        commit(32'h6);
        chk("al_insn", bus.o_insn_cnt, 32'd1);
`ifdef TB_MON_ALIGN_CHK_EN
        chk("al_done", 32'(bus.o_done), 32'd1);
        chk("al_code", 32'(bus.o_fail_code), 32'd4);
`else
        chk("al_done", 32'(bus.o_done), 32'd0);
        chk("al_code", 32'(bus.o_fail_code), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tb_commit_monitor.md
# tb_commit_monitor

Parametrised end-of-test monitor for the RISC-V core bench. It watches the core's commit stream (`o_pc_debug` and `o_insn_vld`) and detects program completion, which the core signals by jumping to itself. It checks the final LEDR value against an expected result and reports pass or fail with a cause code. It also detects global timeout and commit stalls, and counts cycles and retired instructions, replacing the fixed bench timeout with a decision made in RTL.

## Interface
- `PC_W`, 32: width of the debug PC.
- `CNT_W`, 32: width of the cycle and instruction counters.
- `TIMEOUT_CYC`, 40000: global cycle budget after reset.
- `STALL_CYC`, 1024: maximum consecutive cycles without `i_insn_vld` once running.
- `HALT_REPEAT`, 4: consecutive valid commits at the same PC that declare a halt; must be at least 2.
- `i_clk`  in  1: clock.
- `i_reset`  in  1: synchronous reset, active-high.
- `i_pc_debug`  in  PC_W: PC of the committing instruction.
- `i_insn_vld`  in  1: commit valid.
- `i_io_ledr`  in  32: core LEDR output.
- `i_expect_ledr`  in  32: expected final LEDR value; static during the run.
- `o_done`  out  1: verdict reached; sticky.
- `o_pass`  out  1: verdict is pass; only meaningful with `o_done`.
- `o_fail_code`  out  3: 0 none, 1 timeout, 2 stall, 3 mismatch, 4 misaligned PC.
- `o_cyc_cnt`  out  CNT_W: cycles since reset; saturating.
- `o_insn_cnt`  out  CNT_W: valid commits since reset; saturating.

## Operation
- States: WAIT, RUN, CHECK, DONE.
- WAIT
  - Idles until the first `i_insn_vld`, then moves to RUN.
  - That first commit counts and seeds `last_pc`, with the repeat count set to 1.
- RUN, on each valid commit:
  - `insn_cnt` increments.
  - If the PC equals `last_pc`, `rep_cnt` increments; otherwise `rep_cnt` becomes 1 and `last_pc` is updated.
  - When `rep_cnt` reaches `HALT_REPEAT`, the block moves to CHECK.
- Stall:
  - `stall_cnt` clears on every valid commit and increments on every RUN cycle without one.
  - Reaching `STALL_CYC` moves to DONE with code 2.
- Timeout:
  - `cyc_cnt` increments every cycle outside DONE.
  - `cyc_cnt` reaching `TIMEOUT_CYC` in WAIT, RUN or CHECK moves to DONE with code 1.
- CHECK: a single cycle.
  - It samples `i_io_ledr`.
  - If it equals `i_expect_ledr`, the block moves to DONE with pass.
  - Otherwise it moves to DONE with code 3.
- DONE
  - Absorbing until reset.
  - Counters freeze; commit inputs are ignored.
- Simultaneous-event priority, highest first: halt detect, then mismatch/pass in CHECK, then misaligned PC, then stall, then timeout.
- Counters saturate at all-ones and never wrap.
- `rep_cnt` is `$clog2(HALT_REPEAT+1)` bits wide.
- `i_reset` asserted in any state returns the block to WAIT with every register cleared on the next edge.

## Timing
- Reset values: `o_done` 0, `o_pass` 0, `o_fail_code` 0, `o_cyc_cnt` 0, `o_insn_cnt` 0; state is WAIT.
- All outputs are registered.
- The edge that samples the `HALT_REPEAT`-th same-PC commit enters CHECK.
- The next edge enters DONE; `o_done` and `o_pass` are visible one cycle after the CHECK cycle.
- Fault detection (stall, timeout, misalignment) drives `o_done` and `o_fail_code` on the edge after the triggering condition is sampled.
- `o_cyc_cnt` reads N after N post-reset edges.

## Configuration
- Macro: `TB_MON_ALIGN_CHK_EN`.
- Defined:
  - In WAIT or RUN, a valid commit with `i_pc_debug[1:0]` not equal to 0 moves to DONE with code 4.
  - The failing commit is still counted.
- Undefined: no alignment check exists, and code 4 is never produced.

## Structure
- Package `tb_mon_pkg` holds:
  - the `mon_state_e` enum (WAIT, RUN, CHECK, DONE);
  - the `fail_code_e` enum (NONE=0, TIMEOUT=1, STALL=2, MISMATCH=3, MISALIGN=4);
  - the fail-code width constant.
- Sub-module `tb_sat_cnt` (parameter `W`; ports: clear, enable, count) implements a saturating counter.
- `tb_sat_cnt` is instantiated for the cycle, instruction and stall counters.

## Test plan
- Halt pass:
  - Stimulus: commits at PCs 0x0, 0x4, 0x8, 0xC, then 0xC ×3 (`HALT_REPEAT`=4), with `i_io_ledr` = `i_expect_ledr` = 0x2A.
  - Response: `o_done`=1, `o_pass`=1, `o_fail_code`=0, `o_insn_cnt`=7.
- Mismatch:
  - Stimulus: same commit sequence, with `i_io_ledr`=0x29 and `i_expect_ledr`=0x2A.
  - Response: `o_done`=1, `o_pass`=0, `o_fail_code`=3.
- Stall:
  - Stimulus: `STALL_CYC`=16; one commit, then `i_insn_vld` held low.
  - Response: `o_fail_code`=2, `o_done`=1 on the 17th cycle after the commit; counters frozen thereafter.
- Timeout:
  - Stimulus: `TIMEOUT_CYC`=100 and `i_insn_vld` never asserted.
  - Response: `o_fail_code`=1, `o_cyc_cnt` frozen at 100.
- Priority and reset:
  - Stimulus: halt completes on the same edge that `cyc_cnt` reaches `TIMEOUT_CYC`.
  - Response: CHECK is entered and a pass is reported.
  - Then `i_reset` pulses in DONE: all outputs return to 0 one edge later.
- Alignment (`TB_MON_ALIGN_CHK_EN` defined):
  - Stimulus: commit at PC 0x6.
  - Response: `o_fail_code`=4 and `o_insn_cnt`=1.
  - With the macro undefined, the same stimulus produces no fault.
